// File: rtl/sum_uart_pkg.sv
// Shared types and constants for the sum UART transmitter.
// One 16-bit word is sent as two 8N1 frames, high byte first.
package sum_uart_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int FRAME_BITS           = 10;
    localparam int DATA_BITS            = FRAME_BITS - 2;
    localparam int BYTES_PER_WORD       = 2;
    localparam int DEFAULT_CLKS_PER_BIT = 434;
endpackage

// File: rtl/uart_baud_tick.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and pulses o_tick on the last count.
// i_restart holds the counter at 0 so the first bit after a restart is full length.
module uart_baud_tick
    import sum_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(CLKS_PER_BIT - 1));
    assign o_tick = w_last & ~i_restart;

    always_ff @(posedge clk) begin
        if (rst || i_restart) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/sum_uart_tx.sv
// Serialises a 16-bit sum word as two back-to-back 8N1 UART frames.
// tx and busy are registered from the next-state values, so both follow accept by one cycle.
module sum_uart_tx
    import sum_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sum_in,
    input  logic        sum_valid,
    output logic        sum_ready,
    output logic        tx,
    output logic        busy
);
    state_e      r_state, w_next;
    logic        w_tick, w_accept;
    logic [15:0] r_shift, w_shift_next;
    logic [2:0]  r_bit_idx, w_bit_idx_next;
    logic        r_byte_idx, w_byte_idx_next;
    logic        r_tx, w_tx_next;
    logic        r_busy;

    assign sum_ready = (r_state == IDLE);
    assign w_accept  = (r_state == IDLE) && sum_valid;
    assign tx        = r_tx;
    assign busy      = r_busy;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .i_restart(r_state == IDLE),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (sum_valid) w_next = START;
            START: if (w_tick) w_next = DATA;
            DATA:  if (w_tick && r_bit_idx == 3'(DATA_BITS - 1)) w_next = STOP;
            STOP:  if (w_tick) w_next = (r_byte_idx == 1'(BYTES_PER_WORD - 1)) ? IDLE : START;
            default: w_next = IDLE;
        endcase
    end

    // Shift register holds {low byte, high byte} so bit 0 is always the next data bit out.
    always_comb begin
        w_shift_next    = r_shift;
        w_bit_idx_next  = r_bit_idx;
        w_byte_idx_next = r_byte_idx;
        if (w_accept) begin
            w_shift_next    = {sum_in[7:0], sum_in[15:8]};
            w_bit_idx_next  = '0;
            w_byte_idx_next = 1'b0;
        end else if (r_state == DATA && w_tick) begin
            w_shift_next   = {1'b0, r_shift[15:1]};
            w_bit_idx_next = r_bit_idx + 1'b1;
        end else if (r_state == STOP && w_tick) begin
            w_byte_idx_next = ~r_byte_idx;
        end

        case (w_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_shift    <= w_shift_next;
            r_bit_idx  <= w_bit_idx_next;
            r_byte_idx <= w_byte_idx_next;
            r_tx       <= w_tx_next;
            r_busy     <= (w_next != IDLE);
        end
    end
endmodule

// File: tb/tb_sum_uart_tx.sv
// Bench for sum_uart_tx: per-cycle queue model of the expected tx waveform for two
// instances (4 and 2 clocks per bit) plus hand-computed literal checks.
module tb_sum_uart_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a_in = '0, b_in = '0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, a_tx, a_busy;
    logic        b_ready, b_tx, b_busy;
    logic        chk_en = 1'b0;
    int          vectors = 0;
    int          errors  = 0;
    logic        qa[$];
    logic        qb[$];

    // A5 then 5A, each framed start / LSB-first data / stop
    logic [0:19] a55a_bits = 20'b0101001011_0010110101;

    always #5 clk = ~clk;

    sum_uart_tx #(.CLKS_PER_BIT(4)) u_dut_a (
        .clk(clk), .rst(rst), .sum_in(a_in), .sum_valid(a_valid),
        .sum_ready(a_ready), .tx(a_tx), .busy(a_busy)
    );

    sum_uart_tx #(.CLKS_PER_BIT(2)) u_dut_b (
        .clk(clk), .rst(rst), .sum_in(b_in), .sum_valid(b_valid),
        .sum_ready(b_ready), .tx(b_tx), .busy(b_busy)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Bit k (0..19) of the line pattern for one word.
    function automatic logic frame_bit(input logic [15:0] w, input int k);
        int         pos = k % 10;
        logic [7:0] byt = (k < 10) ? w[15:8] : w[7:0];
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return byt[pos-1];
    endfunction

    // Model: queue holds the tx level for every remaining busy cycle.
    always @(posedge clk) begin
        if (rst) qa.delete();
        else if (qa.size() == 0) begin
            if (a_valid)
                for (int k = 0; k < 20; k++)
                    for (int c = 0; c < 4; c++) qa.push_back(frame_bit(a_in, k));
        end else void'(qa.pop_front());
    end

    always @(posedge clk) begin
        if (rst) qb.delete();
        else if (qb.size() == 0) begin
            if (b_valid)
                for (int k = 0; k < 20; k++)
                    for (int c = 0; c < 2; c++) qb.push_back(frame_bit(b_in, k));
        end else void'(qb.pop_front());
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_tx",    a_tx,    (qa.size() != 0) ? qa[0] : 1'b1);
            check("a_busy",  a_busy,  qa.size() != 0);
            check("a_ready", a_ready, qa.size() == 0);
            check("b_tx",    b_tx,    (qb.size() != 0) ? qb[0] : 1'b1);
            check("b_busy",  b_busy,  qb.size() != 0);
            check("b_ready", b_ready, qb.size() == 0);
        end
    end

    initial begin
        int bcnt;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", a_ready, 1'b1);
        for (int i = 0; i < 20; i++) begin
            check("idle_tx", a_tx, 1'b1);
            check("idle_busy", a_busy, 1'b0);
            @(negedge clk);
        end

        // A55A, sum_in scrambled after accept
        a_in = 16'hA55A; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0; a_in = 16'h0000;
        for (int cyc = 1; cyc <= 81; cyc++) begin
            if (cyc == 1) check("a55a_start_lat", a_tx, 1'b0);
            if (cyc <= 80 && (cyc - 1) % 4 == 1)
                check("a55a_bit", a_tx, a55a_bits[(cyc - 1) / 4]);
            if (cyc == 80) check("a55a_busy80", a_busy, 1'b1);
            if (cyc == 80) check("a55a_ready80", a_ready, 1'b0);
            if (cyc == 81) check("a55a_ready81", a_ready, 1'b1);
            if (cyc == 81) check("a55a_busy81", a_busy, 1'b0);
            @(negedge clk);
        end

        // 0001 then FFFF held valid through the whole transaction
        a_in = 16'h0001; a_valid = 1'b1;
        @(negedge clk);
        a_in = 16'hFFFF;
        for (int cyc = 1; cyc <= 81; cyc++) begin
            if (cyc == 6)  check("w0001_hi_bit0", a_tx, 1'b0);
            if (cyc == 46) check("w0001_lo_bit0", a_tx, 1'b1);
            if (cyc == 81) check("b2b_ready", a_ready, 1'b1);
            @(negedge clk);
        end
        check("b2b_start", a_tx, 1'b0);
        check("b2b_busy", a_busy, 1'b1);
        a_valid = 1'b0;
        repeat (82) @(negedge clk);

        // Reset in the middle of 1234
        a_in = 16'h1234; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        repeat (29) @(negedge clk);
        check("mid_busy30", a_busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx", a_tx, 1'b1);
        check("abort_busy", a_busy, 1'b0);
        check("abort_ready", a_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        a_in = 16'h00FF; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        for (int cyc = 1; cyc <= 81; cyc++) begin
            if (cyc == 6)  check("w00ff_hi_bit0", a_tx, 1'b0);
            if (cyc == 46) check("w00ff_lo_bit0", a_tx, 1'b1);
            if (cyc == 81) check("w00ff_ready", a_ready, 1'b1);
            @(negedge clk);
        end

        // Reset and valid in the same cycle
        rst = 1'b1; a_valid = 1'b1; a_in = 16'hBEEF;
        @(negedge clk);
        rst = 1'b0; a_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("rstprio_tx", a_tx, 1'b1);
            check("rstprio_busy", a_busy, 1'b0);
            @(negedge clk);
        end

        // 2 clocks per bit, 8000
        b_in = 16'h8000; b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        bcnt = 0;
        for (int cyc = 1; cyc <= 41; cyc++) begin
            if (b_busy) bcnt++;
            if (cyc == 1)  check("c2_start", b_tx, 1'b0);
            if (cyc == 16) check("c2_bit6", b_tx, 1'b0);
            if (cyc == 17) check("c2_bit7a", b_tx, 1'b1);
            if (cyc == 18) check("c2_bit7b", b_tx, 1'b1);
            if (cyc == 22) check("c2_lo_start", b_tx, 1'b0);
            if (cyc == 41) check("c2_ready41", b_ready, 1'b1);
            @(negedge clk);
        end
        check("c2_busy_cycles", bcnt, 40);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
